board_mem_arbiter: RTL and testbench

// - Shares one single-port synchronous board RAM (26x26 cells, 3-bit colour) between the VGA

---
 rtl/board_pkg.sv | 37 +++
 rtl/board_clear_seq.sv | 71 +++++++
 rtl/board_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_board_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants and types for the board RAM arbiter: board geometry, colour codes,
// read-return tags and clear-sequencer state encoding.
package board_pkg;

    localparam int unsigned BOARD_DIM = 26;
    localparam int unsigned CELLS     = BOARD_DIM * BOARD_DIM;
    localparam int unsigned AW        = 10;
    localparam int unsigned CW        = 3;

    localparam logic [CW-1:0] COL_BLACK   = 3'd0;
    localparam logic [CW-1:0] COL_RED     = 3'd1;
    localparam logic [CW-1:0] COL_GREEN   = 3'd2;
    localparam logic [CW-1:0] COL_YELLOW  = 3'd3;
    localparam logic [CW-1:0] COL_BLUE    = 3'd4;
    localparam logic [CW-1:0] COL_MAGENTA = 3'd5;
    localparam logic [CW-1:0] COL_CYAN    = 3'd6;
    localparam logic [CW-1:0] COL_WHITE   = 3'd7;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_GAME = 2'd2
    } tag_e;

    // oor marks a read that skipped the RAM and must return colour 0
    typedef struct packed {
        tag_e tag;
        logic oor;
    } rd_tag_t;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StClear   = 2'd1,
        StClrDone = 2'd2
    } clr_state_e;

endpackage

// File: rtl/board_clear_seq.sv
// Board clear sequencer: sweeps every cell with a latched colour, one write per granted
// cycle, then pulses clr_done for a single cycle.
module board_clear_seq
    import board_pkg::*;
(
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          clr_start,
    input  logic [CW-1:0] clr_value,
    input  logic          clr_gnt,
    output logic          clr_req,
    output logic [AW-1:0] clr_addr,
    output logic [CW-1:0] clr_val,
    output logic          clr_claim,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] val_q, val_d;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            addr_q  <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        val_d   = val_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StClear;
                    addr_d  = '0;
                    val_d   = clr_value;
                end
            end
            StClear: begin
                if (clr_gnt) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = StClrDone;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            StClrDone: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign clr_req   = (state_q == StClear);
    assign clr_busy  = (state_q == StClear);
    assign clr_done  = (state_q == StClrDone);
    assign clr_addr  = addr_q;
    assign clr_val   = val_q;
    // A start pulse already outranks a game request in the cycle it arrives
    assign clr_claim = clr_busy || ((state_q == StIdle) && clr_start);

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: display reads first, then clear writes, then game
// requests; registered issue stage and a two-deep tag pipe for read returns.
module board_mem_arbiter
    import board_pkg::*;
#(
    parameter bit WR_VBLANK_ONLY = 1'b1
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          vblank,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [CW-1:0] vid_data,
    input  logic          g_req,
    input  logic          g_we,
    input  logic [AW-1:0] g_addr,
    input  logic [CW-1:0] g_wdata,
    output logic          g_gnt,
    output logic          g_rvalid,
    output logic [CW-1:0] g_rdata,
    input  logic          clr_start,
    input  logic [CW-1:0] clr_value,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [CW-1:0] mem_wdata,
    input  logic [CW-1:0] mem_rdata,
    output logic [15:0]   defer_cnt
);

    localparam logic [AW-1:0] CELL_LIMIT = AW'(CELLS);

    logic          clr_req, clr_gnt, clr_claim;
    logic [AW-1:0] clr_addr;
    logic [CW-1:0] clr_val;
    logic          wr_ok, vid_in, g_in;

    logic          en_d, we_d;
    logic [AW-1:0] addr_d;
    logic [CW-1:0] wdata_d;
    rd_tag_t       tag_d, stage1_q, stage2_q;

    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [CW-1:0] mem_wdata_q;
    logic          vid_valid_q, g_rvalid_q;
    logic [CW-1:0] vid_data_q, g_rdata_q, rdata_ret;
    logic [15:0]   defer_q;

    board_clear_seq u_clear_seq (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_gnt   (clr_gnt),
        .clr_req   (clr_req),
        .clr_addr  (clr_addr),
        .clr_val   (clr_val),
        .clr_claim (clr_claim),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    assign wr_ok   = !WR_VBLANK_ONLY || vblank;
    assign vid_in  = (vid_addr < CELL_LIMIT);
    assign g_in    = (g_addr < CELL_LIMIT);
    assign clr_gnt = clr_req && wr_ok && !vid_req;
    assign g_gnt   = g_req && !vid_req && !clr_claim && (!g_we || wr_ok);

    always_comb begin
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        tag_d   = '{tag: TAG_NONE, oor: 1'b0};
        if (vid_req) begin
            tag_d.tag = TAG_VID;
            tag_d.oor = !vid_in;
            en_d      = vid_in;
            addr_d    = vid_in ? vid_addr : '0;
        end else if (clr_gnt) begin
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = clr_addr;
            wdata_d = clr_val;
        end else if (g_gnt) begin
            // Out-of-range writes are acknowledged but never reach the RAM
            en_d   = g_in;
            we_d   = g_we && g_in;
            addr_d = g_in ? g_addr : '0;
            if (g_we) begin
                wdata_d = g_in ? g_wdata : '0;
            end else begin
                tag_d.tag = TAG_GAME;
                tag_d.oor = !g_in;
            end
        end
    end

    assign rdata_ret = stage2_q.oor ? '0 : mem_rdata;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            stage1_q    <= '{tag: TAG_NONE, oor: 1'b0};
            stage2_q    <= '{tag: TAG_NONE, oor: 1'b0};
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            g_rvalid_q  <= 1'b0;
            g_rdata_q   <= '0;
            defer_q     <= '0;
        end else begin
            mem_en_q    <= en_d;
            mem_we_q    <= we_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            stage1_q    <= tag_d;
            stage2_q    <= stage1_q;
            vid_valid_q <= (stage2_q.tag == TAG_VID);
            g_rvalid_q  <= (stage2_q.tag == TAG_GAME);
            if (stage2_q.tag == TAG_VID) begin
                vid_data_q <= rdata_ret;
            end
            if (stage2_q.tag == TAG_GAME) begin
                g_rdata_q <= rdata_ret;
            end
            if (g_req && !g_gnt && (defer_q != 16'hFFFF)) begin
                defer_q <= defer_q + 16'd1;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_data_q;
    assign g_rvalid  = g_rvalid_q;
    assign g_rdata   = g_rdata_q;
    assign defer_cnt = defer_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: vector table of display reads, directed
// corner sequences, and a randomized run against a behavioural board model.
module tb_board_mem_arbiter;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        vblank, vid_req, g_req, g_we, clr_start;
    logic [9:0]  vid_addr, g_addr;
    logic [2:0]  g_wdata, clr_value;
    logic        vid_valid, g_gnt, g_rvalid, clr_busy, clr_done, mem_en, mem_we;
    logic [2:0]  vid_data, g_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;
    logic [15:0] defer_cnt;

    logic [2:0]  ram [0:1023];
    logic        preload;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 CLOCK = ~CLOCK;

    // Board RAM macro stand-in: synchronous single port, preload fills addr%8
    always @(posedge CLOCK) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 3'(i % 8);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    board_mem_arbiter #(.WR_VBLANK_ONLY(1'b1)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .vblank    (vblank),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_data  (vid_data),
        .g_req     (g_req),
        .g_we      (g_we),
        .g_addr    (g_addr),
        .g_wdata   (g_wdata),
        .g_gnt     (g_gnt),
        .g_rvalid  (g_rvalid),
        .g_rdata   (g_rdata),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .defer_cnt (defer_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic outs_nonzero();
        return |{vid_valid, vid_data, g_gnt, g_rvalid, g_rdata, clr_busy, clr_done,
                 mem_en, mem_we, mem_addr, mem_wdata, defer_cnt};
    endfunction

    task automatic cyc();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle_inputs();
        vblank = 0; vid_req = 0; vid_addr = 0; g_req = 0; g_we = 0; g_addr = 0;
        g_wdata = 0; clr_start = 0; clr_value = 0;
    endtask

    task automatic do_reset(input string name);
        idle_inputs();
        RESET = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;
        check(name, 32'(outs_nonzero()), 0);
        RESET = 1'b0;
        cyc();
    endtask

    task automatic do_preload();
        preload = 1'b1;
        cyc();
        preload = 1'b0;
    endtask

    typedef struct {
        logic [9:0] addr;
        logic       exp_en;
        logic [2:0] exp_data;
    } vvec_t;

    vvec_t vt [28];

    // Randomized-run model state
    logic [2:0] model_mem [0:1023];
    logic       ev_valid [4];
    logic [2:0] ev_data [4];
    logic       eg_valid [4];
    logic [2:0] eg_data [4];

    initial begin
        int k, w, done_exp, done_k, done_n, writes, gnt_early, gnt_k, rv_k, vid_n, vid_v;
        int bad, waited;
        logic [2:0] rv_data;
        logic       act, g_we_m, grant;
        logic [9:0] g_addr_m;
        logic [2:0] g_wdata_m;
        int         defer_m;

        for (int i = 0; i < 26; i++) vt[i] = '{10'(i), 1'b1, 3'(i % 8)};
        vt[26] = '{10'd700, 1'b0, 3'd0};
        vt[27] = '{10'd675, 1'b1, 3'd3};

        preload = 1'b0;
        RESET = 1'b1;
        idle_inputs();
        do_reset("reset_outputs");
        do_preload();

        // Display reads every 16th cycle
        for (int i = 0; i < 28; i++) begin
            vid_req = 1'b1;
            vid_addr = vt[i].addr;
            cyc();
            vid_req = 1'b0;
            check($sformatf("vid_en[%0d]", vt[i].addr), 32'(mem_en), 32'(vt[i].exp_en));
            cyc();
            check($sformatf("vid_early[%0d]", vt[i].addr), 32'(vid_valid), 0);
            cyc();
            check($sformatf("vid_valid[%0d]", vt[i].addr), 32'(vid_valid), 1);
            check($sformatf("vid_data[%0d]", vt[i].addr), 32'(vid_data), 32'(vt[i].exp_data));
            repeat (13) cyc();
        end

        // Game read colliding with a display read
        do_reset("reset_a");
        vid_req = 1; vid_addr = 5; g_req = 1; g_we = 0; g_addr = 27;
        #1 check("coll_gnt_t0", 32'(g_gnt), 0);
        cyc();
        vid_req = 0;
        #1 check("coll_gnt_t1", 32'(g_gnt), 1);
        check("coll_vid_first", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, 10'd5}));
        cyc();
        g_req = 0;
        check("coll_game_issue", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, 10'd27}));
        cyc();
        check("coll_vid_data", 32'({vid_valid, vid_data}), 32'({1'b1, 3'd5}));
        cyc();
        check("coll_g_rdata", 32'({g_rvalid, g_rdata}), 32'({1'b1, 3'd3}));
        check("coll_defer", 32'(defer_cnt), 1);

        // Game write held off until vblank
        do_reset("reset_b");
        g_req = 1; g_we = 1; g_addr = 100; g_wdata = 6;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("vb_hold[%0d]", i), 32'(g_gnt), 0);
            cyc();
        end
        check("vb_defer_count", 32'(defer_cnt), 5);
        vblank = 1;
        #1 check("vb_gnt", 32'(g_gnt), 1);
        cyc();
        g_req = 0;
        check("vb_issue", 32'({mem_en, mem_we, mem_addr, mem_wdata}),
              32'({2'b11, 10'd100, 3'd6}));
        cyc();
        check("vb_ram", 32'(ram[100]), 6);
        check("vb_defer_final", 32'(defer_cnt), 5);

        // Out-of-range read and write
        do_reset("reset_d");
        g_req = 1; g_we = 0; g_addr = 700;
        #1 check("oor_rd_gnt", 32'(g_gnt), 1);
        cyc();
        g_req = 0;
        check("oor_rd_no_en", 32'(mem_en), 0);
        cyc();
        cyc();
        check("oor_rd_data", 32'({g_rvalid, g_rdata}), 32'({1'b1, 3'd0}));
        vblank = 1; g_req = 1; g_we = 1; g_addr = 800; g_wdata = 7;
        #1 check("oor_wr_gnt", 32'(g_gnt), 1);
        cyc();
        g_req = 0;
        check("oor_wr_no_en", 32'(mem_en), 0);
        cyc();
        check("oor_wr_ram", 32'(ram[800]), 0);

        // Randomized traffic against the board model
        do_reset("reset_rand");
        do_preload();
        for (int i = 0; i < 1024; i++) model_mem[i] = 3'(i % 8);
        for (int i = 0; i < 4; i++) begin
            ev_valid[i] = 0; ev_data[i] = 0; eg_valid[i] = 0; eg_data[i] = 0;
        end
        act = 0; g_we_m = 0; g_addr_m = 0; g_wdata_m = 0; defer_m = 0;
        for (int c = 0; c < 500; c++) begin
            check("rnd_vid_valid", 32'(vid_valid), 32'(ev_valid[c % 4]));
            if (ev_valid[c % 4]) check("rnd_vid_data", 32'(vid_data), 32'(ev_data[c % 4]));
            check("rnd_g_rvalid", 32'(g_rvalid), 32'(eg_valid[c % 4]));
            if (eg_valid[c % 4]) check("rnd_g_rdata", 32'(g_rdata), 32'(eg_data[c % 4]));
            check("rnd_defer", 32'(defer_cnt), 32'(defer_m));
            ev_valid[c % 4] = 0;
            eg_valid[c % 4] = 0;

            vblank = 1'($urandom_range(0, 1));
            vid_req = ($urandom_range(0, 3) == 0);
            vid_addr = 10'($urandom_range(0, 799));
            if (!act && $urandom_range(0, 1) == 1) begin
                act = 1;
                g_we_m = 1'($urandom_range(0, 1));
                g_addr_m = 10'($urandom_range(0, 799));
                g_wdata_m = 3'($urandom_range(0, 7));
            end
            g_req = act; g_we = g_we_m; g_addr = g_addr_m; g_wdata = g_wdata_m;

            grant = act && !vid_req && (!g_we_m || vblank);
            #1 check("rnd_gnt", 32'(g_gnt), 32'(grant));
            if (vid_req) begin
                ev_valid[(c + 3) % 4] = 1;
                ev_data[(c + 3) % 4] = (vid_addr < 676) ? model_mem[vid_addr] : 3'd0;
            end
            if (grant) begin
                if (!g_we_m) begin
                    eg_valid[(c + 3) % 4] = 1;
                    eg_data[(c + 3) % 4] = (g_addr_m < 676) ? model_mem[g_addr_m] : 3'd0;
                end else if (g_addr_m < 676) begin
                    model_mem[g_addr_m] = g_wdata_m;
                end
                act = 0;
            end else if (act && defer_m < 65535) begin
                defer_m++;
            end
            cyc();
        end

        // Full clear with periodic display reads and a waiting game read
        do_reset("reset_c");
        w = 0;
        k = 0;
        while (w < 676) begin
            if (k % 16 != 0) w++;
            k++;
        end
        done_exp = k;
        vblank = 1; clr_start = 1; clr_value = 3; g_req = 1; g_we = 0; g_addr = 10;
        #1 check("clr_start_blocks_game", 32'(g_gnt), 0);
        cyc();
        clr_start = 0;
        done_k = -1; done_n = 0; writes = 0; gnt_early = 0; gnt_k = -1; rv_k = -1;
        rv_data = 0; vid_n = 0; vid_v = 0;
        for (int j = 0; j < done_exp + 10; j++) begin
            vid_req = (j < done_exp) && (j % 16 == 0);
            vid_addr = 10'((j / 16) % 26);
            #1;
            if (g_gnt) begin
                if (j < done_exp) gnt_early++;
                else if (gnt_k < 0) gnt_k = j;
            end
            if (mem_en && mem_we) writes++;
            if (clr_done) begin done_n++; done_k = j; end
            if (vid_valid) vid_v++;
            if (vid_req) vid_n++;
            if (g_rvalid) begin rv_k = j; rv_data = g_rdata; end
            cyc();
            if (gnt_k >= 0) g_req = 0;
        end
        check("clr_writes", 32'(writes), 676);
        check("clr_done_cycle", 32'(done_k), 32'(done_exp));
        check("clr_done_pulses", 32'(done_n), 1);
        check("clr_gnt_blocked", 32'(gnt_early), 0);
        check("clr_game_granted", 32'(gnt_k >= 0), 1);
        check("clr_game_rd_cycle", 32'(rv_k), 32'(gnt_k + 3));
        check("clr_game_rd_data", 32'(rv_data), 3);
        check("clr_vid_not_lost", 32'(vid_v), 32'(vid_n));
        check("clr_busy_end", 32'(clr_busy), 0);
        bad = 0;
        for (int i = 0; i < 676; i++) if (ram[i] !== 3'd3) bad++;
        check("clr_cells_bad", 32'(bad), 0);

        // Reset in the middle of a sweep
        do_reset("reset_e");
        vblank = 1; clr_start = 1; clr_value = 5;
        cyc();
        clr_start = 0;
        waited = 0;
        while (!(mem_en && mem_we && mem_addr == 10'd300) && waited < 1000) begin
            cyc();
            waited++;
        end
        check("midreset_reached_300", 32'(waited < 1000), 1);
        #2 RESET = 1'b1;
        #1 check("midreset_outs", 32'(outs_nonzero()), 0);
        cyc();
        RESET = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (outs_nonzero()) bad++;
        end
        check("midreset_quiet", 32'(bad), 0);
        clr_start = 1; clr_value = 2;
        cyc();
        clr_start = 0;
        check("restart_busy", 32'(clr_busy), 1);
        cyc();
        check("restart_addr0", 32'({mem_en, mem_we, mem_addr, mem_wdata}),
              32'({2'b11, 10'd0, 3'd2}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
